alarm_set_ctrl: RTL and testbench
=================================

Name: alarm_set_ctrl

Overview:
- Button-driven programming controller for the alarm time and alarm enable.
- Produces alarm_hour, alarm_min, alarm_sec and alarm_en, which drive the alarm comparator's alarm inputs.
- Edits are made in shadow registers and committed atomically, so the comparator never sees a partially edited time.
- Sits between the debounced front-panel buttons and the alarm comparator.

Parameters:
- HOLD_CYCLES, 8: consecutive cycles an inc/dec button must be held after its press edge before auto-repeat starts.
- REPEAT_CYCLES, 4: period in cycles between auto-repeat steps once repeat is active.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- btn_mode  in  1  debounced level; rising edge advances the edit field
- btn_inc  in  1  debounced level; increment the current field
- btn_dec  in  1  debounced level; decrement the current field
- btn_cancel  in  1  debounced level; rising edge abandons the edit
- btn_en  in  1  debounced level; rising edge toggles alarm_en (IDLE only)
- alarm_hour  out  5  committed alarm hour, 0..23
- alarm_min  out  6  committed alarm minute, 0..59
- alarm_sec  out  6  committed alarm second, 0..59
- alarm_en  out  1  committed alarm enable
- edit_field  out  2  0 = idle, 1 = hour, 2 = min, 3 = sec (display blink select)
- shadow_val  out  6  value of the field under edit, zero-extended; 0 in IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - alarm_hour, alarm_min, alarm_sec, alarm_en, edit_field and shadow_val are 0.
  - State is IDLE.
  - Button history registers reset to 1, so a button already held at reset release gives no edge until it is released and pressed again.
  - Repeat counters reset to 0.
- Edge detection: edge = btn & ~btn_q. The effect of an edge is visible in the registered outputs one cycle after the sampling clock edge.
- FSM states: IDLE, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
  - IDLE -> SET_HOUR on a mode edge. Shadow registers load from the committed alarm_* values on that transition.
  - SET_HOUR -> SET_MIN -> SET_SEC on mode edges.
  - SET_SEC -> COMMIT on a mode edge.
  - COMMIT lasts one cycle: alarm_hour/min/sec <= shadow, then -> IDLE.
  - A cancel edge in any SET_* state -> IDLE. Shadow is discarded and outputs are unchanged.
  - A cancel edge in IDLE or COMMIT is ignored; COMMIT always completes.
  - A mode edge and a cancel edge in the same cycle: cancel wins.
- Step rules (SET_* states only):
  - A step is +1 or -1 applied to the active shadow field.
  - Hour wraps 23 -> 0 and 0 -> 23.
  - Min and sec wrap 59 -> 0 and 0 -> 59.
  - Arithmetic must never produce 24..31 or 60..63.
- Step generation per button:
  - A step fires on the press edge.
  - The per-button counter then counts held cycles. When the count reaches HOLD_CYCLES, a step fires. After that, a step fires every REPEAT_CYCLES cycles while the button stays held.
  - Release clears the counter.
- Conflicting buttons:
  - inc and dec both high: no step, and both counters are cleared.
  - A step and a mode edge in the same cycle: the field change takes priority and the step is dropped.
- Field change: entering a new SET_* field clears both repeat counters, so repeat restarts only after a fresh edge.
- Enable toggle: a btn_en edge toggles alarm_en in IDLE only; it is ignored in every other state. Editing does not change alarm_en.
- Output tracking:
  - edit_field follows the state; COMMIT reports 3.
  - shadow_val shows the active shadow field.
- Buttons in IDLE: inc and dec are ignored.
- Reset mid-edit: everything returns to reset values; the committed alarm is cleared to 00:00:00 with the alarm disabled.

Decomposition:
- Package alarm_pkg:
  - state enum
  - field codes (FIELD_IDLE, FIELD_HOUR, FIELD_MIN, FIELD_SEC)
  - HOUR_MAX = 23, MINSEC_MAX = 59
  - field widths 5 and 6
- Sub-module btn_step_gen:
  - edge detect plus hold/auto-repeat counter, parameterised by HOLD_CYCLES and REPEAT_CYCLES
  - outputs a one-cycle step pulse
  - instantiated for inc and for dec
- Mode, cancel and en use plain edge detectors in the top level.

Test Plan:
- Reset, then pulse mode, pulse inc 3 times, mode, mode, mode -> after COMMIT alarm = 03:00:00 with alarm_en = 0; edit_field goes 1, 2, 3, 3, 0.
- In SET_HOUR from 00, pulse dec once -> shadow_val = 23. In SET_MIN at 59, pulse inc -> shadow_val = 0. In SET_SEC at 0, pulse dec -> 59.
- Hold inc for 20 cycles in SET_MIN starting from 10, with HOLD_CYCLES = 8 and REPEAT_CYCLES = 4 -> steps at cycles 0, 8, 12, 16 from the edge; shadow_val = 14; committed alarm unchanged until COMMIT.
- Commit alarm 12:34:56. Enter edit, inc the hour to 13, then cancel edge -> alarm stays 12:34:56 and edit_field = 0. A simultaneous mode and cancel edge in SET_SEC -> no commit.
- btn_en edge in IDLE -> alarm_en = 1. btn_en edge in SET_MIN -> alarm_en stays 1. inc and dec held together for 10 cycles -> shadow unchanged.
- Assert reset asynchronously mid-SET_SEC with alarm 07:08:09 committed -> outputs go to 0 immediately, without waiting for clk. With btn_mode held high through reset release -> no transition until it is released and pressed again.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types, field codes and bounded wrap arithmetic for the alarm programming controller.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_HOUR,
        ST_SET_MIN,
        ST_SET_SEC,
        ST_COMMIT
    } state_t;

    localparam logic [1:0] FIELD_IDLE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam int HOUR_W   = 5;
    localparam int MINSEC_W = 6;

    localparam logic [5:0] HOUR_MAX   = 6'd23;
    localparam logic [5:0] MINSEC_MAX = 6'd59;

    // Out-of-range inputs fold back into range, so a step can never leave 0..max.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
        return (v >= max) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
        return (v == 6'd0 || v > max) ? max : v - 6'd1;
    endfunction

endpackage

// File: rtl/btn_step_gen.sv
// Press-edge detector with hold-then-auto-repeat; emits a one-cycle step pulse.
module btn_step_gen #(
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic clr,
    output logic step
);

    localparam int CW = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] LAST_C = CW'(HOLD_CYCLES + REPEAT_CYCLES - 1);

    logic          btn_q;
    logic [CW-1:0] cnt;
    logic          press;
    logic          held;

    assign press = btn & ~btn_q;
    assign held  = btn & btn_q;
    assign step  = press | (held && cnt == HOLD_C);

    // cnt == 0 while held means repeat is disarmed until a fresh press edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q <= 1'b1;
            cnt   <= '0;
        end else begin
            btn_q <= btn;
            if (clr || !btn) begin
                cnt <= '0;
            end else if (press) begin
                cnt <= CW'(1);
            end else if (cnt != '0) begin
                cnt <= (cnt == LAST_C) ? HOLD_C : cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alarm_set_ctrl.sv
// Alarm time/enable programming FSM: edits in shadow registers, commits all three fields at once.
module alarm_set_ctrl
    import alarm_pkg::*;
#(
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_mode,
    input  logic                btn_inc,
    input  logic                btn_dec,
    input  logic                btn_cancel,
    input  logic                btn_en,
    output logic [HOUR_W-1:0]   alarm_hour,
    output logic [MINSEC_W-1:0] alarm_min,
    output logic [MINSEC_W-1:0] alarm_sec,
    output logic                alarm_en,
    output logic [1:0]          edit_field,
    output logic [5:0]          shadow_val
);

    state_t              state;
    logic [HOUR_W-1:0]   sh_hour;
    logic [MINSEC_W-1:0] sh_min;
    logic [MINSEC_W-1:0] sh_sec;
    logic                mode_q, cancel_q, en_q;
    logic                mode_edge, cancel_edge, en_edge;
    logic                inc_step, dec_step, step_up, step_dn, cnt_clr, field_enter;
    logic [5:0]          cur_val, cur_max, nxt_val;

    assign mode_edge   = btn_mode & ~mode_q;
    assign cancel_edge = btn_cancel & ~cancel_q;
    assign en_edge     = btn_en & ~en_q;

    assign field_enter = mode_edge & ((state == ST_IDLE) |
                         (((state == ST_SET_HOUR) | (state == ST_SET_MIN)) & ~cancel_edge));
    assign cnt_clr = (btn_inc & btn_dec) | field_enter;
    assign step_up = inc_step & ~btn_dec;
    assign step_dn = dec_step & ~btn_inc;

    btn_step_gen #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_inc (
        .clk(clk), .reset(reset), .btn(btn_inc), .clr(cnt_clr), .step(inc_step)
    );

    btn_step_gen #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dec (
        .clk(clk), .reset(reset), .btn(btn_dec), .clr(cnt_clr), .step(dec_step)
    );

    always_comb begin
        cur_val = 6'd0;
        cur_max = MINSEC_MAX;
        case (state)
            ST_SET_HOUR: begin cur_val = {1'b0, sh_hour}; cur_max = HOUR_MAX; end
            ST_SET_MIN:  cur_val = sh_min;
            ST_SET_SEC:  cur_val = sh_sec;
            default:     cur_val = 6'd0;
        endcase
        nxt_val = cur_val;
        if (step_up)      nxt_val = wrap_inc(cur_val, cur_max);
        else if (step_dn) nxt_val = wrap_dec(cur_val, cur_max);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            sh_hour    <= '0;
            sh_min     <= '0;
            sh_sec     <= '0;
            alarm_hour <= '0;
            alarm_min  <= '0;
            alarm_sec  <= '0;
            alarm_en   <= 1'b0;
            edit_field <= FIELD_IDLE;
            shadow_val <= 6'd0;
            mode_q     <= 1'b1;
            cancel_q   <= 1'b1;
            en_q       <= 1'b1;
        end else begin
            mode_q   <= btn_mode;
            cancel_q <= btn_cancel;
            en_q     <= btn_en;
            case (state)
                ST_IDLE: begin
                    if (en_edge) alarm_en <= ~alarm_en;
                    if (mode_edge) begin
                        state      <= ST_SET_HOUR;
                        sh_hour    <= alarm_hour;
                        sh_min     <= alarm_min;
                        sh_sec     <= alarm_sec;
                        edit_field <= FIELD_HOUR;
                        shadow_val <= {1'b0, alarm_hour};
                    end
                end
                ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
                    if (cancel_edge) begin
                        state      <= ST_IDLE;
                        edit_field <= FIELD_IDLE;
                        shadow_val <= 6'd0;
                    end else if (mode_edge) begin
                        // A step arriving with the mode edge is dropped in favour of the field change.
                        case (state)
                            ST_SET_HOUR: begin
                                state <= ST_SET_MIN; edit_field <= FIELD_MIN; shadow_val <= sh_min;
                            end
                            ST_SET_MIN: begin
                                state <= ST_SET_SEC; edit_field <= FIELD_SEC; shadow_val <= sh_sec;
                            end
                            default: begin
                                state <= ST_COMMIT; edit_field <= FIELD_SEC; shadow_val <= sh_sec;
                            end
                        endcase
                    end else if (step_up | step_dn) begin
                        shadow_val <= nxt_val;
                        case (state)
                            ST_SET_HOUR: sh_hour <= nxt_val[HOUR_W-1:0];
                            ST_SET_MIN:  sh_min  <= nxt_val;
                            default:     sh_sec  <= nxt_val;
                        endcase
                    end
                end
                ST_COMMIT: begin
                    alarm_hour <= sh_hour;
                    alarm_min  <= sh_min;
                    alarm_sec  <= sh_sec;
                    state      <= ST_IDLE;
                    edit_field <= FIELD_IDLE;
                    shadow_val <= 6'd0;
                end
                default: begin
                    state      <= ST_IDLE;
                    edit_field <= FIELD_IDLE;
                    shadow_val <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed bench for alarm_set_ctrl with hand-computed expected values.
module tb_alarm_set_ctrl;

    localparam int B_MODE   = 0;
    localparam int B_INC    = 1;
    localparam int B_DEC    = 2;
    localparam int B_CANCEL = 3;
    localparam int B_EN     = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_inc, btn_dec, btn_cancel, btn_en;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min, alarm_sec;
    logic       alarm_en;
    logic [1:0] edit_field;
    logic [5:0] shadow_val;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alarm_set_ctrl #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .btn_cancel(btn_cancel), .btn_en(btn_en),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_sec(alarm_sec),
        .alarm_en(alarm_en), .edit_field(edit_field), .shadow_val(shadow_val)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_MODE:   btn_mode   = v;
            B_INC:    btn_inc    = v;
            B_DEC:    btn_dec    = v;
            B_CANCEL: btn_cancel = v;
            default:  btn_en     = v;
        endcase
    endtask

    task automatic press(input int b, input int times);
        for (int i = 0; i < times; i++) begin
            set_btn(b, 1'b1);
            tick(1);
            set_btn(b, 1'b0);
            tick(1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic check_alarm(input string tag, input int h, input int m, input int s);
        check_eq({tag, "_hour"}, 32'(alarm_hour), 32'(h));
        check_eq({tag, "_min"},  32'(alarm_min),  32'(m));
        check_eq({tag, "_sec"},  32'(alarm_sec),  32'(s));
    endtask

    initial begin
        reset = 1'b1;
        btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_cancel = 0; btn_en = 0;
        tick(2);
        reset = 1'b0;
        tick(1);

        // Reset state
        check_alarm("rst", 0, 0, 0);
        check_eq("rst_en", 32'(alarm_en), 0);
        check_eq("rst_field", 32'(edit_field), 0);
        check_eq("rst_shadow", 32'(shadow_val), 0);

        // Basic edit and commit: 03:00:00
        press(B_MODE, 1);
        check_eq("t1_field_hour", 32'(edit_field), 1);
        press(B_INC, 3);
        check_eq("t1_shadow_3", 32'(shadow_val), 3);
        check_eq("t1_hour_uncommitted", 32'(alarm_hour), 0);
        press(B_MODE, 1);
        check_eq("t1_field_min", 32'(edit_field), 2);
        press(B_MODE, 1);
        check_eq("t1_field_sec", 32'(edit_field), 3);
        btn_mode = 1; tick(1);
        check_eq("t1_field_commit", 32'(edit_field), 3);
        check_eq("t1_hour_pre_commit", 32'(alarm_hour), 0);
        tick(1); btn_mode = 0;
        check_eq("t1_field_idle", 32'(edit_field), 0);
        check_alarm("t1", 3, 0, 0);
        check_eq("t1_en", 32'(alarm_en), 0);
        tick(1);

        // Wrap boundaries
        do_reset();
        press(B_MODE, 1);
        press(B_DEC, 1);
        check_eq("t2_hour_wrap_dn", 32'(shadow_val), 23);
        press(B_INC, 1);
        check_eq("t2_hour_wrap_up", 32'(shadow_val), 0);
        press(B_MODE, 1);
        press(B_DEC, 1);
        check_eq("t2_min_wrap_dn", 32'(shadow_val), 59);
        press(B_INC, 1);
        check_eq("t2_min_wrap_up", 32'(shadow_val), 0);
        press(B_MODE, 1);
        press(B_DEC, 1);
        check_eq("t2_sec_wrap_dn", 32'(shadow_val), 59);
        press(B_CANCEL, 1);
        check_eq("t2_cancel_field", 32'(edit_field), 0);
        check_eq("t2_cancel_shadow", 32'(shadow_val), 0);
        check_alarm("t2", 0, 0, 0);

        // Hold/auto-repeat in SET_MIN from 10: steps at cycles 0, 8, 12, 16
        do_reset();
        press(B_MODE, 2);
        press(B_INC, 10);
        check_eq("t3_start", 32'(shadow_val), 10);
        btn_inc = 1;
        tick(1);
        check_eq("t3_edge_step", 32'(shadow_val), 11);
        tick(7);
        check_eq("t3_before_hold", 32'(shadow_val), 11);
        tick(1);
        check_eq("t3_hold_step", 32'(shadow_val), 12);
        tick(3);
        check_eq("t3_before_repeat", 32'(shadow_val), 12);
        tick(1);
        check_eq("t3_repeat_1", 32'(shadow_val), 13);
        tick(7);
        btn_inc = 0;
        tick(1);
        check_eq("t3_final", 32'(shadow_val), 14);
        check_eq("t3_min_uncommitted", 32'(alarm_min), 0);
        press(B_MODE, 2);
        check_alarm("t3_commit", 0, 14, 0);

        // Cancel and simultaneous mode+cancel
        do_reset();
        press(B_MODE, 1); press(B_INC, 12);
        press(B_MODE, 1); press(B_INC, 34);
        press(B_MODE, 1); press(B_INC, 56);
        press(B_MODE, 1);
        check_alarm("t4_commit", 12, 34, 56);
        press(B_MODE, 1);
        check_eq("t4_load_hour", 32'(shadow_val), 12);
        press(B_INC, 1);
        check_eq("t4_hour_13", 32'(shadow_val), 13);
        press(B_CANCEL, 1);
        check_eq("t4_cancel_field", 32'(edit_field), 0);
        check_alarm("t4_cancel", 12, 34, 56);
        press(B_MODE, 3);
        check_eq("t4_in_sec", 32'(edit_field), 3);
        press(B_INC, 1);
        btn_mode = 1; btn_cancel = 1;
        tick(1);
        check_eq("t4_mc_field", 32'(edit_field), 0);
        btn_mode = 0; btn_cancel = 0;
        tick(2);
        check_alarm("t4_mc", 12, 34, 56);

        // Enable toggle and conflicting inc/dec
        press(B_EN, 1);
        check_eq("t5_en_idle", 32'(alarm_en), 1);
        press(B_MODE, 2);
        press(B_EN, 1);
        check_eq("t5_en_edit", 32'(alarm_en), 1);
        check_eq("t5_min_shadow", 32'(shadow_val), 34);
        btn_inc = 1; btn_dec = 1;
        tick(10);
        btn_inc = 0; btn_dec = 0;
        tick(1);
        check_eq("t5_both_held", 32'(shadow_val), 34);
        press(B_CANCEL, 1);
        check_eq("t5_en_after", 32'(alarm_en), 1);

        // Asynchronous reset mid-SET_SEC with 07:08:09 committed
        do_reset();
        press(B_MODE, 1); press(B_INC, 7);
        press(B_MODE, 1); press(B_INC, 8);
        press(B_MODE, 1); press(B_INC, 9);
        press(B_MODE, 1);
        press(B_EN, 1);
        check_alarm("t6_commit", 7, 8, 9);
        check_eq("t6_en", 32'(alarm_en), 1);
        press(B_MODE, 3);
        check_eq("t6_in_sec", 32'(edit_field), 3);
        #3;
        reset = 1'b1;
        btn_mode = 1'b1;
        #1;
        check_alarm("t6_async", 0, 0, 0);
        check_eq("t6_async_en", 32'(alarm_en), 0);
        check_eq("t6_async_field", 32'(edit_field), 0);
        check_eq("t6_async_shadow", 32'(shadow_val), 0);
        tick(1);
        reset = 1'b0;
        tick(3);
        check_eq("t6_held_mode", 32'(edit_field), 0);
        btn_mode = 1'b0;
        tick(1);
        press(B_MODE, 1);
        check_eq("t6_repress_mode", 32'(edit_field), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
